rps_match_driver: RTL and testbench
===================================

// Module: rps_match_driver
// PURPOSE
//  Initiator side of the rock-paper-scissors referee interface. Drives the referee FSMD's
//  init/move inputs (i, p, s) from a buffered queue of host move pairs and reads back the
//  per-round result m and the match result pa. Keeps win/tie/invalid counters.
//  Sits between the host/testbench sequencer and the referee FSMD.
// PARAMETERS
//  FIFO_DEPTH  4   move-pair queue depth (power of 2, >=2)
//  RESP_LAT    1   cycles from move drive to sampling g_m/g_pa (>=1)
//  MAX_MOVES   32  moves issued before a forced timeout end of match
// PORTS
//  clk        in   1  single clock, all state on posedge
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  pulse: begin match (accepted in IDLE/DONE only)
//  cfg_rounds in   5  max rounds, legal 4..19 (clamped into range)
//  mv_valid   in   1  host move-pair valid
//  mv_ready   out  1  queue not full (0 while rst)
//  mv_p       in   2  player-1 move (00 none, 01 rock, 10 paper, 11 scissors)
//  mv_s       in   2  player-2 move (same encoding)
//  g_i        out  1  referee init strobe
//  g_p, g_s   out  2  moves to referee
//  g_m        in   2  referee round result (00 invalid, 01 P1, 10 P2, 11 tie)
//  g_pa       in   2  referee match result (00 running, 01 P1, 10 P2, 11 draw)
//  busy       out  1  match in progress
//  done       out  1  one-cycle pulse at match end
//  winner     out  2  latched g_pa at end (00 on timeout), held until next start
//  timeout    out  1  set when MAX_MOVES hit, cleared on start
//  wins1, wins2, ties, invalids  out 6 each  saturating round counters, cleared on start
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, state IDLE, counters 0.
//  Handshake: push when mv_valid&&mv_ready. Pushes are legal in any state.
//   Queue flushed on start and on rst.
//  FSM: IDLE -> INIT -> PLAY -> GAP -> (PLAY | DONE); DONE -> INIT on start.
//   INIT (1 cycle): g_i=1, g_p=(cfg_rounds-4)>>2, g_s=(cfg_rounds-4)&3; busy=1.
//   PLAY: if queue empty, stall with g_p=g_s=00 and no counter change.
//    Else pop, drive the pair for exactly 1 cycle, move count+1 -> GAP.
//   GAP: g_p=g_s=00 for RESP_LAT cycles. Sample g_m/g_pa on the last GAP cycle.
//    Bump the counter selected by g_m. Counters saturate at 63.
//    Then: g_pa!=00 -> DONE. Move count==MAX_MOVES -> DONE with timeout=1.
//    Otherwise back to PLAY.
//   DONE: done=1 for the entry cycle only, busy=0, winner latched, g_*=0.
//  Pair with 00 in either field: forwarded unchanged. The referee counts it invalid.
//  Repeated-move filtering is left to the referee; the driver forwards every pair.
//  start while busy: ignored. Push and pop in the same cycle: both occur, count unchanged.
//  rst mid-match: immediate return to the reset state, including g_i=0.
// CONFIGURATION
//  RPS_DRV_LFSR_EN defined: in PLAY with an empty queue, no stall.
//   Moves come from an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst/start).
//   Mapping: g_p={lfsr[1:0]==0 ? 01 : lfsr[1:0]}, g_s from lfsr[3:2] the same way.
//   The LFSR advances once per generated pair.
//  RPS_DRV_LFSR_EN undefined: empty queue stalls as above; no LFSR logic.
// STRUCTURE
//  rps_pkg: move_t (NONE/ROCK/PAPER/SCISSORS), round_t (INVALID/P1/P2/TIE),
//   match_t (RUN/P1/P2/DRAW), drv_state_t enum, MIN_ROUNDS=4, MAX_ROUNDS=19.
//  Sub-module rps_move_fifo: synchronous FIFO of {p,s} 4-bit entries, flush input.
// TESTING
//  1. rounds=4, start -> one cycle g_i=1, g_p=00, g_s=00. rounds=19 -> g_p=11, g_s=11.
//     rounds=25 -> clamped, g_p=11, g_s=11.
//  2. push {01,11}, model returns g_m=01 -> g_p/g_s=01/11 for one cycle, then wins1=1.
//  3. queue empty in PLAY for 10 cycles -> g_p=g_s=00, counters unchanged.
//     With LFSR_EN: first pair derived from 8'hA5 -> g_p=01, g_s=01.
//  4. fill 4 entries -> mv_ready=0. Pop and push in the same cycle -> mv_ready stays 0,
//     entry order preserved.
//  5. model returns g_pa=10 -> done pulse for 1 cycle, winner=10, busy=0,
//     remaining queue entries not popped.
//  6. MAX_MOVES=4, all g_m=00 -> invalids=4, timeout=1, winner=00.
//     rst asserted in GAP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rps_pkg.sv
// rps_pkg: shared encodings, FSM state type and small helpers for the
// rock-paper-scissors referee driver (rps_match_driver, rps_move_fifo).
package rps_pkg;

    typedef enum logic [1:0] {
        MV_NONE     = 2'b00,
        MV_ROCK     = 2'b01,
        MV_PAPER    = 2'b10,
        MV_SCISSORS = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        RND_INVALID = 2'b00,
        RND_P1      = 2'b01,
        RND_P2      = 2'b10,
        RND_TIE     = 2'b11
    } round_t;

    typedef enum logic [1:0] {
        MATCH_RUN  = 2'b00,
        MATCH_P1   = 2'b01,
        MATCH_P2   = 2'b10,
        MATCH_DRAW = 2'b11
    } match_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_PLAY,
        S_GAP,
        S_DONE
    } drv_state_t;

    typedef struct packed {
        move_t p;
        move_t s;
    } pair_t;

    localparam int         MIN_ROUNDS = 4;
    localparam int         MAX_ROUNDS = 19;
    localparam logic [5:0] CNT_MAX    = 6'd63;

    // Clamp the requested round count into MIN..MAX and return the
    // 4-bit code the referee expects as {p, s} during init.
    function automatic logic [3:0] rounds_code(input logic [4:0] r);
        logic [4:0] c;
        if (r < 5'(MIN_ROUNDS))
            c = 5'(MIN_ROUNDS);
        else if (r > 5'(MAX_ROUNDS))
            c = 5'(MAX_ROUNDS);
        else
            c = r;
        return 4'(c - 5'(MIN_ROUNDS));
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c == CNT_MAX) ? c : c + 6'd1;
    endfunction

    // Two LFSR bits to a legal move; 00 would be "none" so it maps to rock.
    function automatic move_t lfsr_move(input logic [1:0] b);
        return (b == 2'b00) ? MV_ROCK : move_t'(b);
    endfunction

endpackage

// File: rtl/rps_move_fifo.sv
// rps_move_fifo: synchronous first-word-fall-through FIFO of {p, s} move
// pairs. Ports: clk, rst (async high), flush, push/wdata, pop/rdata, full, empty.
module rps_move_fifo
    import rps_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  push,
    input  pair_t wdata,
    input  logic  pop,
    output pair_t rdata,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);

    pair_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push will use.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rps_match_driver.sv
// rps_match_driver: initiator side of the rock-paper-scissors referee link.
// Queues host move pairs (mv_valid/mv_ready/mv_p/mv_s), drives the referee
// (g_i/g_p/g_s), samples g_m/g_pa, and reports busy/done/winner/timeout plus
// saturating wins1/wins2/ties/invalids counters. Clock clk, async reset rst.
// Optional macro RPS_DRV_LFSR_EN: an empty queue in PLAY yields LFSR moves
// instead of stalling.
module rps_match_driver
    import rps_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RESP_LAT   = 1,
    parameter int MAX_MOVES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] cfg_rounds,
    input  logic       mv_valid,
    output logic       mv_ready,
    input  logic [1:0] mv_p,
    input  logic [1:0] mv_s,
    output logic       g_i,
    output logic [1:0] g_p,
    output logic [1:0] g_s,
    input  logic [1:0] g_m,
    input  logic [1:0] g_pa,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       timeout,
    output logic [5:0] wins1,
    output logic [5:0] wins2,
    output logic [5:0] ties,
    output logic [5:0] invalids
);
    localparam int MW = $clog2(MAX_MOVES + 1);
    localparam int GW = $clog2(RESP_LAT + 1);

    drv_state_t    state;
    logic [MW-1:0] moves;
    logic [GW-1:0] gap_cnt;
    logic          start_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          take;
    pair_t         head;
    pair_t         nxt;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign pop      = (state == S_PLAY) && !fifo_empty;
    // Ready also while full if this cycle pops, so push+pop keeps it full.
    assign mv_ready = !rst && (!fifo_full || pop);
    assign push     = mv_valid && mv_ready;

    rps_move_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_ok),
        .push  (push),
        .wdata ({move_t'(mv_p), move_t'(mv_s)}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef RPS_DRV_LFSR_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;
    logic       gen;

    // Taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign gen     = (state == S_PLAY) && fifo_empty;
    assign take    = (state == S_PLAY);
    assign nxt     = pop ? head
                         : {lfsr_move(lfsr[1:0]), lfsr_move(lfsr[3:2])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 8'hA5;
        else if (start_ok)
            lfsr <= 8'hA5;
        else if (gen)
            lfsr <= {lfsr[6:0], lfsr_fb};
    end
`else
    assign take = pop;
    assign nxt  = head;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            moves    <= '0;
            gap_cnt  <= '0;
            g_i      <= 1'b0;
            g_p      <= 2'b00;
            g_s      <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            winner   <= 2'b00;
            timeout  <= 1'b0;
            wins1    <= '0;
            wins2    <= '0;
            ties     <= '0;
            invalids <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state      <= S_INIT;
                        g_i        <= 1'b1;
                        {g_p, g_s} <= rounds_code(cfg_rounds);
                        busy       <= 1'b1;
                        winner     <= 2'b00;
                        timeout    <= 1'b0;
                        moves      <= '0;
                        wins1      <= '0;
                        wins2      <= '0;
                        ties       <= '0;
                        invalids   <= '0;
                    end
                end
                S_INIT: begin
                    g_i   <= 1'b0;
                    g_p   <= 2'b00;
                    g_s   <= 2'b00;
                    state <= S_PLAY;
                end
                S_PLAY: begin
                    // The pair shows on g_p/g_s during the first GAP cycle.
                    if (take) begin
                        g_p     <= nxt.p;
                        g_s     <= nxt.s;
                        moves   <= moves + MW'(1);
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    g_p <= 2'b00;
                    g_s <= 2'b00;
                    if (gap_cnt == GW'(RESP_LAT)) begin
                        unique case (round_t'(g_m))
                            RND_INVALID: invalids <= sat_inc(invalids);
                            RND_P1:      wins1    <= sat_inc(wins1);
                            RND_P2:      wins2    <= sat_inc(wins2);
                            RND_TIE:     ties     <= sat_inc(ties);
                        endcase
                        if (match_t'(g_pa) != MATCH_RUN) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            winner <= g_pa;
                        end else if (moves == MW'(MAX_MOVES)) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            winner  <= 2'b00;
                            timeout <= 1'b1;
                        end else begin
                            state <= S_PLAY;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_driver.sv
// tb_rps_match_driver: self-checking bench for rps_match_driver with a
// reactive referee model and a match-level reference model.
module tb_rps_match_driver;
    localparam int LAT  = 2;
    localparam int MAXM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] cfg_rounds;
    logic       mv_valid;
    logic       mv_ready;
    logic [1:0] mv_p, mv_s;
    logic       g_i;
    logic [1:0] g_p, g_s, g_m, g_pa;
    logic       busy, done, timeout;
    logic [1:0] winner;
    logic [5:0] wins1, wins2, ties, invalids;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [3:0] obs_q[$];
    logic [3:0] resp_q[$];

    always #5 clk = ~clk;

    rps_match_driver #(
        .FIFO_DEPTH (4),
        .RESP_LAT   (LAT),
        .MAX_MOVES  (MAXM)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rounds(cfg_rounds),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_p(mv_p), .mv_s(mv_s),
        .g_i(g_i), .g_p(g_p), .g_s(g_s), .g_m(g_m), .g_pa(g_pa),
        .busy(busy), .done(done), .winner(winner), .timeout(timeout),
        .wins1(wins1), .wins2(wins2), .ties(ties), .invalids(invalids)
    );

    // Referee model: each forwarded pair gets the next planned {g_m, g_pa},
    // held until the following pair.
    always @(negedge clk) begin
        if (!rst) begin
            if (!g_i && (g_p != 2'b00 || g_s != 2'b00)) begin
                obs_q.push_back({g_p, g_s});
                if (resp_q.size() > 0)
                    {g_m, g_pa} = resp_q.pop_front();
                else
                    {g_m, g_pa} = 4'b0000;
            end
            if (done)
                done_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mv_valid = 1'b0;
        mv_p = 2'b00; mv_s = 2'b00; g_m = 2'b00; g_pa = 2'b00;
        cfg_rounds = 5'd4;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic do_start(input logic [4:0] r);
        obs_q.delete(); resp_q.delete(); done_cnt = 0;
        cfg_rounds = r; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [3:0] pr, input int lim, output bit ok);
        mv_valid = 1'b1; {mv_p, mv_s} = pr; ok = 0;
        for (int k = 0; k < lim && !ok; k++) begin
            if (mv_ready) ok = 1;
            step();
        end
        mv_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 100 && busy; k++) step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s_idle got busy=%b want 0", nm, busy);
        end
    endtask

    task automatic wait_obs(input int n, input string nm);
        for (int k = 0; k < 60 && obs_q.size() < n; k++) step();
        total++;
        if (obs_q.size() < n) begin
            bad++; $display("FAIL %s_obs got %0d pairs want %0d", nm, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mv_valid = 1'b0; g_m = 0; g_pa = 0;
        mv_p = 0; mv_s = 0; cfg_rounds = 5'd4;
        step();
        total++;
        if ({g_i, g_p, g_s, busy, done, winner, timeout, wins1, wins2, ties,
             invalids, mv_ready} !== '0) begin
            bad++; $display("FAIL reset_outs got nonzero want 0");
        end
        rst = 1'b0;
        step();
        total++;
        if ({mv_ready, busy, g_i} !== 3'b100) begin
            bad++; $display("FAIL reset_release got %b want 100", {mv_ready, busy, g_i});
        end
    endtask

    task automatic test_init();
        logic [4:0] rs[5];
        int e;
        rs[0] = 5'd4; rs[1] = 5'd19; rs[2] = 5'd25; rs[3] = 5'd0;
        rs[4] = 5'($urandom_range(4, 19));
        for (int i = 0; i < 5; i++) begin
            do_reset();
            do_start(rs[i]);
            e = (rs[i] < 4 ? 4 : (rs[i] > 19 ? 19 : int'(rs[i]))) - 4;
            total++;
            if ({g_i, g_p, g_s, busy} !== {1'b1, 2'(e / 4), 2'(e % 4), 1'b1}) begin
                bad++;
                $display("FAIL init_r%0d got %b want %b", rs[i], {g_i, g_p, g_s, busy},
                         {1'b1, 2'(e / 4), 2'(e % 4), 1'b1});
            end
            step();
            total++;
            if ({g_i, g_p, g_s} !== 5'b0) begin
                bad++; $display("FAIL init_end_r%0d got %b want 0", rs[i], {g_i, g_p, g_s});
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        do_start(5'd4);
        resp_q.push_back(4'b0100);
        push(4'b0111, 20, ok);
        wait_obs(1, "single");
        total++;
        if (obs_q.size() == 0 || obs_q[0] !== 4'b0111) begin
            bad++; $display("FAIL single_pair got %h want 7", obs_q.size() ? obs_q[0] : 4'hx);
        end
        step();
        total++;
        if ({g_p, g_s} !== 4'b0) begin
            bad++; $display("FAIL single_width got %b want 0", {g_p, g_s});
        end
        repeat (LAT) step();
        total++;
        if ({wins1, wins2, ties, invalids, busy} !== {6'd1, 6'd0, 6'd0, 6'd0, 1'b1}) begin
            bad++;
            $display("FAIL single_cnt got w1=%0d w2=%0d t=%0d i=%0d b=%b want 1 0 0 0 1",
                     wins1, wins2, ties, invalids, busy);
        end
    endtask

    task automatic test_stall();
`ifdef RPS_DRV_LFSR_EN
        do_reset();
        do_start(5'd4);
        wait_obs(1, "lfsr");
        total++;
        if (obs_q.size() == 0 || obs_q[0] !== 4'b0101) begin
            bad++; $display("FAIL lfsr_first got %h want 5", obs_q.size() ? obs_q[0] : 4'hx);
        end
`else
        step();
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({g_p, g_s, wins1, wins2, ties, invalids, busy} !==
                {4'b0, 6'd1, 6'd0, 6'd0, 6'd0, 1'b1}) begin
                bad++; $display("FAIL stall_c%0d got p=%b s=%b w1=%0d b=%b want 0 0 1 1",
                                c, g_p, g_s, wins1, busy);
            end
            step();
        end
`endif
    endtask

    task automatic test_fill();
        logic [3:0] items[8];
        int acc, occ;
        bit pend, pp_seen;
        do_reset();
        do_start(5'd8);
        for (int i = 0; i < 8; i++) begin
            items[i] = 4'($urandom_range(1, 15));
            resp_q.push_back(4'b0100);
        end
        acc = 0; pend = 0; pp_seen = 0;
        for (int c = 0; c < 80 && acc < 8; c++) begin
            occ = acc - obs_q.size();
            if (pend) begin
                total++;
                if (mv_ready !== 1'b0 || occ != 4) begin
                    bad++; $display("FAIL fill_pushpop got rdy=%b occ=%0d want 0 4", mv_ready, occ);
                end
                pend = 0;
            end
            mv_valid = 1'b1; {mv_p, mv_s} = items[acc];
            if (occ < 4) begin
                total++;
                if (mv_ready !== 1'b1) begin
                    bad++; $display("FAIL fill_ready got %b want 1 occ=%0d", mv_ready, occ);
                end
            end
            if (occ == 4 && mv_ready) begin pp_seen = 1; pend = 1; end
            if (mv_ready) acc++;
            step();
        end
        mv_valid = 1'b0;
        wait_idle("fill");
        repeat (6) step();
        total++;
        if ({8'(acc), pp_seen, mv_ready, timeout, winner, wins1} !==
            {8'd8, 1'b1, 1'b0, 1'b1, 2'b00, 6'd4}) begin
            bad++;
            $display("FAIL fill_end got acc=%0d pp=%b rdy=%b to=%b w=%b w1=%0d want 8 1 0 1 0 4",
                     acc, pp_seen, mv_ready, timeout, winner, wins1);
        end
        total++;
        if (obs_q.size() != 4) begin
            bad++; $display("FAIL fill_pops got %0d want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (obs_q[i] !== items[i]) begin
                    bad++; $display("FAIL fill_order%0d got %h want %h", i, obs_q[i], items[i]);
                end
            end
        end
    endtask

    task automatic test_winner();
        bit ok;
        do_reset();
        do_start(5'd10);
        resp_q.push_back(4'b0100);
        resp_q.push_back(4'b1010);
        resp_q.push_back(4'b1100);
        push(4'b1001, 20, ok);
        push(4'b0110, 20, ok);
        push(4'b1111, 20, ok);
        wait_idle("win");
        total++;
        if ({done, winner} !== 3'b110) begin
            bad++; $display("FAIL win_done got %b want 110", {done, winner});
        end
        step();
        total++;
        if ({done, winner, busy} !== 4'b0100) begin
            bad++; $display("FAIL win_pulse got %b want 0100", {done, winner, busy});
        end
        repeat (8) step();
        total++;
        if (obs_q.size() != 2 || done_cnt != 1 ||
            {wins1, wins2, ties, invalids} !== {6'd1, 6'd1, 6'd0, 6'd0}) begin
            bad++; $display("FAIL win_after got pops=%0d dones=%0d w1=%0d w2=%0d want 2 1 1 1",
                            obs_q.size(), done_cnt, wins1, wins2);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] pr[4];
        bit ok;
        do_reset();
        do_start(5'd7);
        for (int i = 0; i < 4; i++) begin
            pr[i] = (i % 2 == 0) ? {2'b00, 2'($urandom_range(1, 3))}
                                 : {2'($urandom_range(1, 3)), 2'b00};
            resp_q.push_back(4'b0000);
        end
        for (int i = 0; i < 4; i++) push(pr[i], 20, ok);
        wait_idle("tmo");
        total++;
        if ({invalids, wins1, wins2, ties, timeout, winner, done} !==
            {6'd4, 18'd0, 1'b1, 2'b00, 1'b1}) begin
            bad++; $display("FAIL tmo_end got inv=%0d to=%b w=%b d=%b want 4 1 0 1",
                            invalids, timeout, winner, done);
        end
        total++;
        if (obs_q.size() != 4 || obs_q[0] !== pr[0] || obs_q[3] !== pr[3]) begin
            bad++; $display("FAIL tmo_fwd got n=%0d want 4 unchanged", obs_q.size());
        end
        do_start(5'd4);
        total++;
        if ({timeout, busy, invalids} !== {1'b0, 1'b1, 6'd0}) begin
            bad++; $display("FAIL tmo_clear got to=%b b=%b inv=%0d want 0 1 0",
                            timeout, busy, invalids);
        end
        resp_q.push_back(4'b1100);
        resp_q.push_back(4'b1100);
        push(4'b0110, 20, ok);
        push(4'b1011, 20, ok);
        wait_obs(2, "rst");
        total++;
        if ({ties, g_p, g_s} !== {6'd1, 4'b1011}) begin
            bad++; $display("FAIL rst_pre got t=%0d p=%b s=%b want 1 10 11", ties, g_p, g_s);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({g_i, g_p, g_s, busy, done, winner, timeout, wins1, wins2, ties,
             invalids, mv_ready} !== '0) begin
            bad++; $display("FAIL rst_async got t=%0d p=%b b=%b want 0", ties, g_p, busy);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] pr[6], rp[6];
        int n, used, cnt[4];
        logic [1:0] ew;
        bit eto, fin, ok;
        do_reset();
        for (int m = 0; m < 8; m++) begin
            do_start(5'($urandom_range(0, 31)));
            for (int i = 0; i < 6; i++) begin
                pr[i] = 4'($urandom_range(1, 15));
                rp[i] = {2'($urandom_range(0, 3)),
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                resp_q.push_back(rp[i]);
            end
            n = 0;
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 2)) step();
                push(pr[i], 12, ok);
                if (!ok) break;
                n++;
            end
            wait_idle("b2b");
            repeat (5) step();
            used = 0; ew = 2'b00; eto = 0; fin = 0;
            for (int k = 0; k < 4; k++) cnt[k] = 0;
            for (int i = 0; i < n && !fin; i++) begin
                used++;
                cnt[rp[i][3:2]]++;
                if (rp[i][1:0] != 2'b00) begin ew = rp[i][1:0]; fin = 1; end
                else if (used == MAXM) begin eto = 1; fin = 1; end
            end
            total++;
            if ({wins1, wins2, ties, invalids, winner, timeout, 8'(done_cnt)} !==
                {6'(cnt[1]), 6'(cnt[2]), 6'(cnt[3]), 6'(cnt[0]), ew, eto, 8'd1}) begin
                bad++;
                $display("FAIL b2b_m%0d got %0d/%0d/%0d/%0d w=%b to=%b d=%0d want %0d/%0d/%0d/%0d w=%b to=%b d=1",
                         m, wins1, wins2, ties, invalids, winner, timeout, done_cnt,
                         cnt[1], cnt[2], cnt[3], cnt[0], ew, eto);
            end
            total++;
            if (obs_q.size() != used) begin
                bad++; $display("FAIL b2b_n%0d got %0d want %0d", m, obs_q.size(), used);
            end else begin
                for (int i = 0; i < used; i++) begin
                    if (obs_q[i] !== pr[i]) begin
                        bad++; $display("FAIL b2b_p%0d_%0d got %h want %h", m, i, obs_q[i], pr[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_single();
        test_stall();
        test_fill();
        test_winner();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
